// File: rtl/vscale_pkg.sv
// vscale_pkg: shared types and constants for the vscale fetch slice.
// Holds the sequencer state enum, Wishbone field widths and default halt word.
package vscale_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [31:0] DEFAULT_HALT_INSN = 32'h0000_006F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/vscale_if.sv
// vscale_if: Wishbone classic bus bundle.
// master: cyc/stb/we/adr/sel/dat_w out, dat_r/ack in; slave: the reverse.
interface vscale_if;
    import vscale_pkg::*;

    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] dat_w;
    logic [WB_DAT_W-1:0] dat_r;
    logic                ack;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack
    );

endinterface

// File: rtl/wb_bfm_memory.sv
// wb_bfm_memory: word-addressed Wishbone memory, MEM_WORDS x 32, aliasing.
// Ports: clk, rst_n (async, low), wb (slave). Ack and read data one cycle after stb.
module wb_bfm_memory
    import vscale_pkg::*;
#(
    parameter int MEM_WORDS = 8192
) (
    input logic     clk,
    input logic     rst_n,
    vscale_if.slave wb
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic          req;
    logic          unused_adr;

    // Upper address bits are ignored, so the array aliases.
    assign idx        = wb.adr[AW+1:2];
    assign unused_adr = ^{wb.adr[WB_ADR_W-1:AW+2], wb.adr[1:0]};

    // Suppressing a new request during ack gives one ack per transfer.
    assign req = wb.cyc & wb.stb & ~wb.ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.ack <= 1'b0;
        end else begin
            wb.ack <= req;
        end
    end

    // Array has no reset: contents survive reset.
    always_ff @(posedge clk) begin
        if (req) begin
            if (wb.we) begin
                for (int b = 0; b < WB_SEL_W; b++) begin
                    if (wb.sel[b]) begin
                        mem[idx][8*b +: 8] <= wb.dat_w[8*b +: 8];
                    end
                end
            end else begin
                wb.dat_r <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/vscale_top.sv
// vscale_top: instruction fetch sequencer over a Wishbone memory, halts on HALT_INSN.
// Ports: wb_clk_i, wb_rst_i (async, low), pc_o, instr_o, instr_valid_o, halted_o.
// Optional: define VSCALE_TRACE_EN to print each fetch and the HALT entry.
module vscale_top
    import vscale_pkg::*;
#(
    parameter int          MEM_WORDS = 8192,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN = DEFAULT_HALT_INSN
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        halted_o
);

    localparam logic [31:0] LAST_PC = 32'(MEM_WORDS * 4 - 4);

    vscale_if wb ();

    seq_state_t  state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        cyc_q;

    assign next_pc = (pc == LAST_PC) ? RESET_PC : pc + 32'd4;

    // Gating with ack drops cyc/stb during the ack cycle, so the
    // next request can start right after it: one word per 2 cycles.
    assign wb.cyc   = cyc_q & ~wb.ack;
    assign wb.stb   = cyc_q & ~wb.ack;
    assign wb.we    = 1'b0;
    assign wb.sel   = 4'hF;
    assign wb.dat_w = '0;
    assign wb.adr   = pc;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            pc_o          <= '0;
            instr_o       <= '0;
            instr_valid_o <= 1'b0;
            halted_o      <= 1'b0;
            cyc_q         <= 1'b0;
        end else begin
            instr_valid_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                    cyc_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (wb.ack) begin
                        pc_o          <= pc;
                        instr_o       <= wb.dat_r;
                        instr_valid_o <= 1'b1;
                        if (wb.dat_r == HALT_INSN) begin
                            state    <= ST_HALT;
                            cyc_q    <= 1'b0;
                            halted_o <= 1'b1;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                ST_HALT: begin
                    cyc_q    <= 1'b0;
                    halted_o <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

    wb_bfm_memory #(
        .MEM_WORDS(MEM_WORDS)
    ) wb_bfm_memory0 (
        .clk  (wb_clk_i),
        .rst_n(wb_rst_i),
        .wb   (wb)
    );

`ifdef VSCALE_TRACE_EN
    always @(posedge wb_clk_i) begin
        if (wb_rst_i && state == ST_FETCH && wb.ack) begin
            $display("%0t pc=%h insn=%h", $time, pc, wb.dat_r);
            if (wb.dat_r == HALT_INSN) begin
                $display("%0t HALT pc=%h", $time, pc);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vscale_top.sv
// tb_vscale_top: randomized self-checking bench for vscale_top.
// Fetch stream compared against a queue/array model of the fetch rules.
module tb_vscale_top;
    import vscale_pkg::*;

    localparam int          MW   = 16;
    localparam logic [31:0] HALT = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        halted_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [MW];

    always #5 clk = ~clk;

    vscale_top #(
        .MEM_WORDS(MW)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst_n),
        .pc_o         (pc_o),
        .instr_o      (instr_o),
        .instr_valid_o(instr_valid_o),
        .halted_o     (halted_o)
    );

    vscale_if mwb ();

    wb_bfm_memory #(
        .MEM_WORDS(MW)
    ) u_mem (
        .clk  (clk),
        .rst_n(rst_n),
        .wb   (mwb)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = w ^ 32'h1;
        return w;
    endfunction

    // Load model into DUT memory while held in reset, then release.
    task automatic reset_and_load(input bit load);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        if (load) begin
            for (int i = 0; i < MW; i++) begin
                dut.wb_bfm_memory0.mem[i] = model_mem[i];
            end
        end
        rst_n = 1'b1;
    endtask

    // Expected stream: fetch word at pc, halt on HALT, else advance with wrap.
    task automatic run_fetch(input int n);
        int          cyc = 0;
        int          got = 0;
        int          last = 0;
        logic [31:0] m_pc = 32'h0;
        logic [31:0] w;
        bit          m_halt = 1'b0;
        while (got < n && !m_halt && cyc < 4 * n + 10) begin
            @(posedge clk);
            #1;
            cyc++;
            if (instr_valid_o) begin
                w = model_mem[(m_pc / 4) % MW];
                chk("pc", pc_o, m_pc);
                chk("insn", instr_o, w);
                chk("gap", cyc - last, (got == 0) ? 3 : 2);
                last = cyc;
                got++;
                if (w == HALT) m_halt = 1'b1;
                else m_pc = (m_pc == MW * 4 - 4) ? 32'h0 : m_pc + 32'd4;
                chk("halted", {31'b0, halted_o}, {31'b0, m_halt});
            end
        end
        if (!m_halt) chk("fetch_count", got, n);
    endtask

    task automatic check_halt_quiet();
        logic busy = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            busy = busy | instr_valid_o | dut.wb.cyc | ~halted_o;
        end
        chk("halt_quiet", {31'b0, busy}, 32'h0);
    endtask

    task automatic mem_xfer(input bit we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dw,
                            output logic [31:0] dr);
        bit ok = 1'b0;
        dr = 'x;
        @(negedge clk);
        mwb.cyc   = 1'b1;
        mwb.stb   = 1'b1;
        mwb.we    = we;
        mwb.adr   = adr;
        mwb.sel   = sel;
        mwb.dat_w = dw;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (mwb.ack) begin
                ok = 1'b1;
                dr = mwb.dat_r;
            end
        end
        mwb.cyc = 1'b0;
        mwb.stb = 1'b0;
        mwb.we  = 1'b0;
        chk("mem_ack", {31'b0, ok}, 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] pre;
        logic [31:0] dw;
        logic [31:0] exp;
        logic [3:0]  sel;
        int          idx;
        bit          ok;

        mwb.cyc   = 1'b0;
        mwb.stb   = 1'b0;
        mwb.we    = 1'b0;
        mwb.adr   = '0;
        mwb.sel   = '0;
        mwb.dat_w = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_pc_o", pc_o, 32'h0);
        chk("rst_instr_o", instr_o, 32'h0);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("rst_halted", {31'b0, halted_o}, 32'h0);
        chk("rst_cyc", {31'b0, dut.wb.cyc}, 32'h0);
        chk("rst_ack", {31'b0, dut.wb.ack}, 32'h0);

        // Directed 3-word program ending in HALT.
        for (int i = 0; i < MW; i++) model_mem[i] = rand_word();
        model_mem[0] = 32'h11;
        model_mem[1] = 32'h22;
        model_mem[2] = HALT;
        reset_and_load(1'b1);
        run_fetch(3);
        check_halt_quiet();

        // Reset pulse on halted design: restart with memory intact.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_unhalt", {31'b0, halted_o}, 32'h0);
        reset_and_load(1'b0);
        run_fetch(3);

        // No HALT in memory: pc wraps after last word.
        for (int i = 0; i < MW; i++) model_mem[i] = rand_word();
        reset_and_load(1'b1);
        run_fetch(MW + 4);

        // Reset while stb is high aborts the transfer.
        repeat (3) @(posedge clk);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (dut.wb.stb) ok = 1'b1;
        end
        chk("stb_seen", {31'b0, ok}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_cyc", {31'b0, dut.wb.cyc}, 32'h0);
        chk("abort_stb", {31'b0, dut.wb.stb}, 32'h0);
        chk("abort_valid", {31'b0, instr_valid_o}, 32'h0);
        reset_and_load(1'b0);
        run_fetch(4);

        // Randomized programs, HALT at a random word or absent.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < MW; i++) model_mem[i] = rand_word();
            if ($urandom_range(0, 3) != 0) begin
                model_mem[$urandom_range(0, MW - 1)] = HALT;
            end
            reset_and_load(1'b1);
            run_fetch(MW + 6);
        end

        // Direct bus byte-lane write over zero.
        u_mem.mem[5] = 32'h0;
        mem_xfer(1'b1, 32'd20, 4'b0101, 32'hAABB_CCDD, rd);
        chk("lane_write", u_mem.mem[5], 32'h00BB_00DD);
        mem_xfer(1'b0, 32'd20 + MW * 4, 4'hF, 32'h0, rd);
        chk("alias_read", rd, 32'h00BB_00DD);

        // Random lane writes read back over the bus.
        for (int t = 0; t < 4; t++) begin
            idx = $urandom_range(0, MW - 1);
            pre = $urandom;
            dw  = $urandom;
            sel = 4'($urandom);
            u_mem.mem[idx] = pre;
            exp = pre;
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) exp[8*b +: 8] = dw[8*b +: 8];
            end
            mem_xfer(1'b1, 32'(idx * 4), sel, dw, rd);
            mem_xfer(1'b0, 32'(idx * 4), 4'hF, 32'h0, rd);
            chk("rand_lane", rd, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
